// File: rtl/stage_decode.sv
// RV32I decode stage: field decode, immediate generation, 32x32 register file read,
// RAW hazard detection and the decode->execute pipeline register.
// Optional macro STAGE_DECODE_BYPASS_EN forwards same-cycle wb writes into operand reads.
module stage_decode (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        de_valid,
  input  logic [31:0] de_insn,
  input  logic [31:0] de_pc,
  output logic        de_stall,
  input  logic        de_flush,
  input  logic        ex_stall,
  input  logic        mem_wen,
  input  logic [4:0]  mem_rd,
  input  logic        wb_wen,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [3:0]  ex_op,
  output logic [2:0]  ex_funct3,
  output logic        ex_alt,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [4:0]  ex_rd,
  output logic        ex_wen,
  output logic        ex_illegal
);

  localparam logic [3:0] OP_LUI    = 4'd0;
  localparam logic [3:0] OP_AUIPC  = 4'd1;
  localparam logic [3:0] OP_JAL    = 4'd2;
  localparam logic [3:0] OP_JALR   = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_LOAD   = 4'd5;
  localparam logic [3:0] OP_STORE  = 4'd6;
  localparam logic [3:0] OP_OPIMM  = 4'd7;
  localparam logic [3:0] OP_OP     = 4'd8;
  localparam logic [3:0] OP_MISC   = 4'd9;
  localparam logic [3:0] OP_SYSTEM = 4'd10;
  localparam logic [3:0] OP_ILL    = 4'd15;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = de_insn[6:0];
  assign funct3 = de_insn[14:12];
  assign funct7 = de_insn[31:25];
  assign rd     = de_insn[11:7];
  assign rs1    = de_insn[19:15];
  assign rs2    = de_insn[24:20];

  assign imm_i = {{20{de_insn[31]}}, de_insn[31:20]};
  assign imm_s = {{20{de_insn[31]}}, de_insn[31:25], de_insn[11:7]};
  assign imm_b = {{19{de_insn[31]}}, de_insn[31], de_insn[7], de_insn[30:25], de_insn[11:8], 1'b0};
  assign imm_u = {de_insn[31:12], 12'b0};
  assign imm_j = {{11{de_insn[31]}}, de_insn[31], de_insn[19:12], de_insn[20], de_insn[30:21], 1'b0};

  logic [3:0]  dec_op;
  logic        dec_illegal;
  logic [31:0] dec_imm;
  logic        dec_wr;
  logic        use_rs1, use_rs2;
  logic        dec_wen;

  always_comb begin
    dec_op      = OP_ILL;
    dec_illegal = 1'b1;
    dec_imm     = 32'd0;
    dec_wr      = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    if (de_insn[1:0] == 2'b11) begin
      case (opcode)
        7'b0110111: begin dec_op = OP_LUI;   dec_illegal = 1'b0; dec_imm = imm_u; dec_wr = 1'b1; end
        7'b0010111: begin dec_op = OP_AUIPC; dec_illegal = 1'b0; dec_imm = imm_u; dec_wr = 1'b1; end
        7'b1101111: begin dec_op = OP_JAL;   dec_illegal = 1'b0; dec_imm = imm_j; dec_wr = 1'b1; end
        7'b1100111: begin
          dec_op = OP_JALR; dec_illegal = 1'b0; dec_imm = imm_i; dec_wr = 1'b1; use_rs1 = 1'b1;
        end
        7'b1100011: if (funct3 != 3'b010 && funct3 != 3'b011) begin
          dec_op = OP_BRANCH; dec_illegal = 1'b0; dec_imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
        7'b0000011: if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
          dec_op = OP_LOAD; dec_illegal = 1'b0; dec_imm = imm_i; dec_wr = 1'b1; use_rs1 = 1'b1;
        end
        7'b0100011: if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
          dec_op = OP_STORE; dec_illegal = 1'b0; dec_imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
        // Shift-immediates reuse imm[11:5] as funct7; only SRAI may set bit 30.
        7'b0010011: if (!((funct3 == 3'b001 && funct7 != 7'b0000000) ||
                          (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000))) begin
          dec_op = OP_OPIMM; dec_illegal = 1'b0; dec_imm = imm_i; dec_wr = 1'b1; use_rs1 = 1'b1;
        end
        7'b0110011: if (funct7 == 7'b0000000 ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec_op = OP_OP; dec_illegal = 1'b0; dec_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        end
        7'b0001111: begin dec_op = OP_MISC; dec_illegal = 1'b0; dec_imm = imm_i; end
        7'b1110011: begin
          dec_op = OP_SYSTEM; dec_illegal = 1'b0; dec_imm = imm_i; dec_wr = 1'b1; use_rs1 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dec_wen = dec_wr & (rd != 5'd0);

  // Register file: x0 is never written and always reads as zero.
  logic [31:0] rf [32];

  always_ff @(posedge clk) begin
    if (wb_wen && wb_rd != 5'd0)
      rf[wb_rd] <= wb_data;
  end

  logic [31:0] rs1_data, rs2_data;

  always_comb begin
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    if (rs1 != 5'd0) rs1_data = rf[rs1];
    if (rs2 != 5'd0) rs2_data = rf[rs2];
`ifdef STAGE_DECODE_BYPASS_EN
    if (wb_wen && rs1 != 5'd0 && wb_rd == rs1) rs1_data = wb_data;
    if (wb_wen && rs2 != 5'd0 && wb_rd == rs2) rs2_data = wb_data;
`endif
  end

  logic hz_rs1, hz_rs2, hazard;

  always_comb begin
    hz_rs1 = use_rs1 && rs1 != 5'd0 &&
             ((ex_valid && ex_wen && ex_rd == rs1) || (mem_wen && mem_rd == rs1));
    hz_rs2 = use_rs2 && rs2 != 5'd0 &&
             ((ex_valid && ex_wen && ex_rd == rs2) || (mem_wen && mem_rd == rs2));
`ifndef STAGE_DECODE_BYPASS_EN
    // Without forwarding the array only holds the wb value after this edge.
    if (use_rs1 && rs1 != 5'd0 && wb_wen && wb_rd == rs1) hz_rs1 = 1'b1;
    if (use_rs2 && rs2 != 5'd0 && wb_wen && wb_rd == rs2) hz_rs2 = 1'b1;
`endif
  end

  assign hazard = hz_rs1 | hz_rs2;

  // Handshakes: fetch->decode transfers when de_valid & ~de_stall & ~de_flush, and fetch
  // holds its word while de_stall is high; decode->execute holds every ex_* while ex_stall is high.
  logic accept;

  assign de_stall = de_valid & ~de_flush & (hazard | ex_stall);
  assign accept   = de_valid & ~de_stall & ~de_flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= 32'd0;
      ex_op       <= 4'd0;
      ex_funct3   <= 3'd0;
      ex_alt      <= 1'b0;
      ex_imm      <= 32'd0;
      ex_rs1_data <= 32'd0;
      ex_rs2_data <= 32'd0;
      ex_rd       <= 5'd0;
      ex_wen      <= 1'b0;
      ex_illegal  <= 1'b0;
    end else if (de_flush) begin
      ex_valid <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid <= accept;
      if (accept) begin
        ex_pc       <= de_pc;
        ex_op       <= dec_op;
        ex_funct3   <= funct3;
        ex_alt      <= de_insn[30];
        ex_imm      <= dec_imm;
        ex_rs1_data <= rs1_data;
        ex_rs2_data <= rs2_data;
        ex_rd       <= rd;
        ex_wen      <= dec_wen;
        ex_illegal  <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_stage_decode.sv
// Directed bench for stage_decode: decode fields, hazard stalls, wb bypass/no-bypass,
// ex_stall hold, flush priority, illegal encodings and asynchronous reset.
module tb_stage_decode;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        de_valid;
  logic [31:0] de_insn;
  logic [31:0] de_pc;
  logic        de_stall;
  logic        de_flush;
  logic        ex_stall;
  logic        mem_wen;
  logic [4:0]  mem_rd;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [3:0]  ex_op;
  logic [2:0]  ex_funct3;
  logic        ex_alt;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic        ex_illegal;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  stage_decode dut (
    .clk(clk), .reset_n(reset_n),
    .de_valid(de_valid), .de_insn(de_insn), .de_pc(de_pc), .de_stall(de_stall),
    .de_flush(de_flush), .ex_stall(ex_stall),
    .mem_wen(mem_wen), .mem_rd(mem_rd),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .ex_funct3(ex_funct3),
    .ex_alt(ex_alt), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, away from sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] insn, input logic [31:0] pc);
    de_valid = 1'b1;
    de_insn  = insn;
    de_pc    = pc;
  endtask

  // Checks an issued instruction against the next expected pc in program order.
  task automatic check_issue(input string tag, input logic [3:0] op, input logic [31:0] imm,
                             input logic [4:0] rd, input logic wen);
    logic [31:0] exp_pc;
    exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    check({tag, "_valid"}, {31'd0, ex_valid}, 32'd1);
    check({tag, "_pc"},    ex_pc, exp_pc);
    check({tag, "_op"},    {28'd0, ex_op}, {28'd0, op});
    check({tag, "_imm"},   ex_imm, imm);
    check({tag, "_rd"},    {27'd0, ex_rd}, {27'd0, rd});
    check({tag, "_wen"},   {31'd0, ex_wen}, {31'd0, wen});
  endtask

  initial begin
    exp_q = '{32'h80000000, 32'h80000004, 32'h80000008, 32'h8000000C,
              32'h80000014, 32'h80000018};
    reset_n  = 1'b0;
    de_valid = 1'b0;
    de_insn  = 32'd0;
    de_pc    = 32'd0;
    de_flush = 1'b0;
    ex_stall = 1'b0;
    mem_wen  = 1'b0;
    mem_rd   = 5'd0;
    wb_wen   = 1'b0;
    wb_rd    = 5'd0;
    wb_data  = 32'd0;
    step();
    step();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_pc",    ex_pc, 32'd0);
    check("rst_op",    {28'd0, ex_op}, 32'd0);
    check("rst_imm",   ex_imm, 32'd0);
    check("rst_ill",   {31'd0, ex_illegal}, 32'd0);
    check("rst_stall", {31'd0, de_stall}, 32'd0);
    reset_n = 1'b1;
    step();

    // addi x1,x0,5
    present(32'h00500093, 32'h80000000);
    #1 check("addi_stall", {31'd0, de_stall}, 32'd0);
    step();
    check_issue("addi", 4'd7, 32'd5, 5'd1, 1'b1);
    check("addi_rs1", ex_rs1_data, 32'd0);

    // add x2,x1,x1 against x1 in execute
    present(32'h00108133, 32'h80000004);
    #1 check("add_hz_ex", {31'd0, de_stall}, 32'd1);
    step();
    check("add_bubble1", {31'd0, ex_valid}, 32'd0);
    mem_wen = 1'b1;
    mem_rd  = 5'd1;
    #1 check("add_hz_mem", {31'd0, de_stall}, 32'd1);
    step();
    check("add_bubble2", {31'd0, ex_valid}, 32'd0);
    mem_wen = 1'b0;
    wb_wen  = 1'b1;
    wb_rd   = 5'd1;
    wb_data = 32'd5;
`ifdef STAGE_DECODE_BYPASS_EN
    #1 check("add_bypass_stall", {31'd0, de_stall}, 32'd0);
    step();
    wb_wen = 1'b0;
`else
    #1 check("add_wb_stall", {31'd0, de_stall}, 32'd1);
    step();
    wb_wen = 1'b0;
    check("add_bubble3", {31'd0, ex_valid}, 32'd0);
    #1 check("add_wb_clear", {31'd0, de_stall}, 32'd0);
    step();
`endif
    check_issue("add", 4'd8, 32'd0, 5'd2, 1'b1);
    check("add_rs1", ex_rs1_data, 32'd5);
    check("add_rs2", ex_rs2_data, 32'd5);

    // beq x0,x0,-4
    present(32'hFE000EE3, 32'h80000008);
    #1 check("beq_stall", {31'd0, de_stall}, 32'd0);
    step();
    check_issue("beq", 4'd4, 32'hFFFFFFFC, 5'd29, 1'b0);

    // addi x3,x0,7 held behind ex_stall
    ex_stall = 1'b1;
    present(32'h00700193, 32'h8000000C);
    for (int i = 0; i < 3; i++) begin
      #1 check("exst_stall", {31'd0, de_stall}, 32'd1);
      step();
      check("exst_valid", {31'd0, ex_valid}, 32'd1);
      check("exst_pc",    ex_pc, 32'h80000008);
      check("exst_op",    {28'd0, ex_op}, 32'd4);
      check("exst_imm",   ex_imm, 32'hFFFFFFFC);
    end
    ex_stall = 1'b0;
    #1 check("exst_release", {31'd0, de_stall}, 32'd0);
    step();
    check_issue("addi7", 4'd7, 32'd7, 5'd3, 1'b1);

    // add x4,x3,x0 hazards on x3, then flush
    present(32'h00018233, 32'h80000010);
    #1 check("fl_hz", {31'd0, de_stall}, 32'd1);
    de_flush = 1'b1;
    #1 check("fl_stall", {31'd0, de_stall}, 32'd0);
    step();
    check("fl_valid", {31'd0, ex_valid}, 32'd0);
    de_flush = 1'b0;
    de_valid = 1'b0;
    step();
    check("idle_valid", {31'd0, ex_valid}, 32'd0);

    // Illegal encodings
    present(32'h00000000, 32'h80000014);
    step();
    check_issue("ill0", 4'd15, 32'd0, 5'd0, 1'b0);
    check("ill0_flag", {31'd0, ex_illegal}, 32'd1);
    present(32'h0000007F, 32'h80000018);
    step();
    check_issue("ill7f", 4'd15, 32'd0, 5'd0, 1'b0);
    check("ill7f_flag", {31'd0, ex_illegal}, 32'd1);

    // Asynchronous reset between edges
    #2 reset_n = 1'b0;
    #1 check("arst_valid", {31'd0, ex_valid}, 32'd0);
    check("arst_ill", {31'd0, ex_illegal}, 32'd0);
    check("arst_pc", ex_pc, 32'd0);
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
